seq_gen: RTL and testbench

Serial pattern transmitter, the source-side counterpart of seq_detect. It accepts a WIDTH-bit parallel word through a load/ready handshake and shifts it out MSB-first on dout, one bit per clk. Back-to-back words stream with no gap. It drives seq_detect.din directly, so the bench-only serial stimulus becomes a synthesizable block.

---
 rtl/seq_pkg.sv | 14 +
 rtl/seq_gen_if.sv | 32 +++
 rtl/seq_gen.sv | 105 ++++++++++
 tb/tb_seq_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the serial pattern transmitter (seq_gen),
// its detector counterpart (seq_detect) and their benches.
//   seq_state_e : 1-bit transmitter state encoding (ST_IDLE / ST_SHIFT)
//   SEQ_WIDTH   : default word width shared by all users
package seq_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } seq_state_e;

  localparam int SEQ_WIDTH = 32;

endpackage : seq_pkg

// File: rtl/seq_gen_if.sv
// seq_gen_if: word-load handshake and serial output bundle of seq_gen.
//   load       word-valid from the source
//   data_in    WIDTH-bit word, MSB transmitted first
//   abort      synchronous cancel of the word being shifted
//   ready      transmitter can accept a word this cycle
//   dout       serial data
//   dout_valid dout carries a word bit
//   last       dout carries bit 0 of a word
// Modports: master = word source / serial sink, slave = transmitter.
interface seq_gen_if #(
  parameter int WIDTH = seq_pkg::SEQ_WIDTH
);

  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             abort;
  logic             ready;
  logic             dout;
  logic             dout_valid;
  logic             last;

  modport master (
    output load, data_in, abort,
    input  ready, dout, dout_valid, last
  );

  modport slave (
    input  load, data_in, abort,
    output ready, dout, dout_valid, last
  );

endinterface : seq_gen_if

// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter.
// Accepts a WIDTH-bit word over a load/ready handshake and shifts it out
// MSB-first on dout, one bit per clk. A word loaded on the last-bit cycle
// follows immediately with no bubble.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_gen_if.slave (load, data_in, abort in; ready, dout,
//          dout_valid, last out)
module seq_gen
  import seq_pkg::*;
#(
  parameter int   WIDTH      = SEQ_WIDTH,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_gen_if.slave  bus
);

  localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  seq_state_e       state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [CNT_W-1:0] cnt_r;
  logic             dout_r;
  logic             dout_valid_r;
  logic             last_r;

  logic             at_last_s;
  logic             ready_s;
  logic             abort_s;
  logic             accept_s;

  // Handshake decode: ready depends only on state and counter, never on load.
  always_comb begin
    at_last_s = (cnt_r == CNT_LAST);
    ready_s   = 1'b0;
    if (state_r == ST_IDLE) begin
      ready_s = 1'b1;
    end else begin
      ready_s = at_last_s;
    end
    // abort only matters while a word is in flight, and it masks a
    // simultaneous load on the last-bit cycle.
    abort_s  = bus.abort && (state_r == ST_SHIFT);
    accept_s = bus.load && ready_s && !abort_s;
  end

  // FSM, shift register, bit counter and registered serial outputs.
  // shreg_r[WIDTH-1] always mirrors the bit currently on dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      shreg_r      <= '0;
      cnt_r        <= '0;
      dout_r       <= IDLE_LEVEL;
      dout_valid_r <= 1'b0;
      last_r       <= 1'b0;
    end else if (abort_s) begin
      state_r      <= ST_IDLE;
      shreg_r      <= '0;
      cnt_r        <= '0;
      dout_r       <= IDLE_LEVEL;
      dout_valid_r <= 1'b0;
      last_r       <= 1'b0;
    end else if (accept_s) begin
      state_r      <= ST_SHIFT;
      shreg_r      <= bus.data_in;
      cnt_r        <= '0;
      dout_r       <= bus.data_in[WIDTH-1];
      dout_valid_r <= 1'b1;
      last_r       <= 1'b0;
    end else if (state_r == ST_SHIFT) begin
      if (at_last_s) begin
        state_r      <= ST_IDLE;
        shreg_r      <= '0;
        cnt_r        <= '0;
        dout_r       <= IDLE_LEVEL;
        dout_valid_r <= 1'b0;
        last_r       <= 1'b0;
      end else begin
        shreg_r      <= {shreg_r[WIDTH-2:0], 1'b0};
        cnt_r        <= cnt_r + CNT_W'(1);
        dout_r       <= shreg_r[WIDTH-2];
        dout_valid_r <= 1'b1;
        last_r       <= ((cnt_r + CNT_W'(1)) == CNT_LAST);
      end
    end else begin
      state_r      <= state_r;
      shreg_r      <= shreg_r;
      cnt_r        <= cnt_r;
      dout_r       <= dout_r;
      dout_valid_r <= dout_valid_r;
      last_r       <= last_r;
    end
  end

  assign bus.ready      = ready_s;
  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.last       = last_r;

endmodule : seq_gen

// File: tb/tb_seq_gen.sv
// tb_seq_gen: randomized self-checking bench for seq_gen.
// The reference model is a queue of the serial bits still to appear on
// dout (with a parallel queue marking each word's final bit); the transmitter
// is ready whenever at most one bit is left in flight.
module tb_seq_gen;
  import seq_pkg::*;

  localparam int W = SEQ_WIDTH;

  logic clk;
  logic rst_n;

  seq_gen_if #(.WIDTH(W)) bus ();

  seq_gen #(
    .WIDTH      (W),
    .IDLE_LEVEL (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: bits still to be shown on dout, front = current bit
  logic exp_bits[$];
  logic exp_last[$];

  function automatic logic [3:0] exp_vec();
    // {dout, dout_valid, last, ready}
    if (exp_bits.size() == 0) return {1'b0, 1'b0, 1'b0, 1'b1};
    return {exp_bits[0], 1'b1, exp_last[0], (exp_bits.size() == 1)};
  endfunction

  function automatic logic [3:0] got_vec();
    return {bus.dout, bus.dout_valid, bus.last, bus.ready};
  endfunction

  function automatic void model_clear();
    exp_bits.delete();
    exp_last.delete();
  endfunction

  // one clock: drive inputs after negedge, advance the model at posedge,
  // return 1 ns later so the caller samples away from the edge
  task automatic drive(input logic ld, input logic [W-1:0] d, input logic ab);
    bit busy;
    bit m_ready;
    @(negedge clk);
    bus.load    = ld;
    bus.data_in = d;
    bus.abort   = ab;
    @(posedge clk);
    busy    = (exp_bits.size() != 0);
    m_ready = (exp_bits.size() <= 1);
    if (ab && busy) begin
      model_clear();
    end else begin
      if (busy) begin
        void'(exp_bits.pop_front());
        void'(exp_last.pop_front());
      end
      if (ld && m_ready) begin
        for (int k = W - 1; k >= 0; k--) begin
          exp_bits.push_back(d[k]);
          exp_last.push_back(k == 0);
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    rst_n       = 1'b0;
    bus.load    = 1'b1;
    bus.data_in = 32'hA5A5_A5A5;
    bus.abort   = 1'b0;
    model_clear();
    #12;
    got = got_vec();
    n_tests++;
    if (got[3:1] !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_hold: got dout/valid/last=%b want 000", got[3:1]);
    end
    #13;  // release at t=25 ns, a falling clock edge
    rst_n    = 1'b1;
    bus.load = 1'b0;
    @(posedge clk);
    #1;
    got = got_vec();
    n_tests++;
    if (got !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_release: got %b want 0001", got);
    end
  endtask

  task automatic test_single_word();
    logic [31:0] word;
    logic [3:0]  got;
    word = 32'h36E1_7A0D;
    drive(1'b1, word, 1'b0);
    for (int i = 0; i < W + 2; i++) begin
      got = got_vec();
      n_tests++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL single_word bit %0d: got %b want %b", i, got, exp_vec());
      end
      // independent spot check of the serial pattern itself
      if (i < W) begin
        n_tests++;
        if (bus.dout !== word[W-1-i] || bus.last !== (i == W - 1)) begin
          n_fail++;
          $display("FAIL single_word_pattern bit %0d: got dout=%b last=%b want dout=%b last=%b",
                   i, bus.dout, bus.last, word[W-1-i], (i == W - 1));
        end
      end
      drive(1'b0, '0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] got;
    int         valid_run;
    int         lasts;
    valid_run = 0;
    lasts     = 0;
    drive(1'b1, 32'h36E1_7A0D, 1'b0);
    for (int i = 0; i < 3 * W; i++) begin
      got = got_vec();
      n_tests++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got %b want %b", i, got, exp_vec());
      end
      if (bus.dout_valid === 1'b1) valid_run++;
      if (bus.last === 1'b1) lasts++;
      // hold the second word's load until the first word's last bit
      drive((i < W), 32'hFFFF_0000, 1'b0);
    end
    n_tests++;
    if (valid_run != 2 * W || lasts != 2) begin
      n_fail++;
      $display("FAIL back_to_back_count: got valid=%0d last=%0d want valid=%0d last=2",
               valid_run, lasts, 2 * W);
    end
  endtask

  task automatic test_ignored_load_abort();
    logic [31:0] word;
    logic [3:0]  got;
    word = $urandom | 32'h8000_0001;
    drive(1'b1, word, 1'b0);                 // bit 0 shown next
    for (int b = 0; b < 12; b++) begin
      got = got_vec();
      n_tests++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL ignore_abort bit %0d: got %b want %b", b, got, exp_vec());
      end
      if (b == 5)       drive(1'b1, 32'h0, 1'b0);        // not ready: ignored
      else if (b == 10) drive(1'b1, 32'hFFFF_FFFF, 1'b1); // abort beats load
      else              drive(1'b0, '0, 1'b0);
      if (b == 10) begin
        got = got_vec();
        n_tests++;
        if (got !== 4'b0001) begin
          n_fail++;
          $display("FAIL abort_idle: got %b want 0001", got);
        end
      end
    end
    // abort while idle does not block a load
    drive(1'b1, 32'hC3C3_0F0F, 1'b1);
    for (int i = 0; i < W + 1; i++) begin
      got = got_vec();
      n_tests++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL abort_in_idle cyc %0d: got %b want %b", i, got, exp_vec());
      end
      drive(1'b0, '0, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] got;
    drive(1'b1, 32'hFFFF_FFFF, 1'b0);
    for (int b = 0; b < 12; b++) drive(1'b0, '0, 1'b0);
    #2;                         // well away from any clock edge
    rst_n = 1'b0;
    model_clear();
    #1;
    got = got_vec();
    n_tests++;
    if (got[3:1] !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: got dout/valid/last=%b want 000", got[3:1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h5A5A_1234, 1'b0);
    for (int i = 0; i < W + 1; i++) begin
      got = got_vec();
      n_tests++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL after_reset cyc %0d: got %b want %b", i, got, exp_vec());
      end
      drive(1'b0, '0, 1'b0);
    end
  endtask

  task automatic test_random();
    logic [3:0]  got;
    logic        ld;
    logic        ab;
    logic [31:0] d;
    for (int i = 0; i < 600; i++) begin
      ld = ($urandom_range(0, 3) != 0);
      ab = ($urandom_range(0, 40) == 0);
      d  = $urandom;
      drive(ld, d, ab);
      got = got_vec();
      n_tests++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b want %b", i, got, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_ignored_load_abort();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_seq_gen
